cpu_controller: RTL and testbench

- Moore control FSM that drives the datapath, instruction register, program counter and RAM control inputs each cycle.
- It is the initiator side of the control interface that the datapath and decoder respond to.
- Inputs are the decoded opcode and op fields of the current instruction.
- Runs a fetch / load-IR / update-PC / decode / execute sequence per instruction.

---
 rtl/cpu_controller.sv | 190 +++++++++++++++++++
 tb/tb_cpu_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: Moore control FSM sequencing fetch / load-IR / update-PC / decode / execute
// for each instruction, driving the datapath, instruction register, PC and RAM controls.
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   reset            synchronous active-low reset (0 = reset)
//   opcode, op       decoded instruction fields, sampled only in DECODE
//   nsel             one-hot register select (001 Rn, 010 Rd, 100 Rm)
//   vsel             write-back source (00 C, 01 sximm8, 10 mdata, 11 PC)
//   loada..loads     datapath register enables
//   asel, bsel       ALU operand selects
//   write            register file write enable
//   loadir           instruction register load
//   loadpc, reset_pc PC load and PC clear select
//   msel, mwrite     RAM address source and write enable
//   halted           high while in HALT
module cpu_controller #(
  parameter int unsigned RESET_HOLD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       loadir,
  output logic       loadpc,
  output logic       reset_pc,
  output logic       msel,
  output logic       mwrite,
  output logic       halted
);

  typedef enum logic [3:0] {
    StReset, StFetch, StLoadIr, StUpdatePc, StDecode, StWrImm, StGetA, StGetB,
    StExec, StWrRd, StAddr, StMemRd, StWrMem, StGetD, StSt, StHalt
  } state_e;

  localparam logic [2:0] HoldCycles = 3'(RESET_HOLD);

  // Instruction codes ({opcode, op}) that the execute states need to tell apart.
  localparam logic [4:0] InsMovReg = 5'b110_00;
  localparam logic [4:0] InsMvn    = 5'b101_11;
  localparam logic [4:0] InsCmp    = 5'b101_01;
  localparam logic [2:0] OpcAlu    = 3'b101;
  localparam logic [2:0] OpcLdr    = 3'b011;

  state_e     state_q, state_d;
  logic [4:0] ins_q, ins_d;    // {opcode, op} captured in DECODE
  logic [2:0] hold_q, hold_d;  // cycles spent in RESET since reset released

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StReset;
      ins_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    hold_d  = hold_q;
    unique case (state_q)
      StReset: begin
        if (hold_q == HoldCycles) begin
          state_d = StFetch;
        end else begin
          hold_d = hold_q + 3'd1;
        end
      end
      StFetch:    state_d = StLoadIr;
      StLoadIr:   state_d = StUpdatePc;
      StUpdatePc: state_d = StDecode;
      StDecode: begin
        ins_d   = {opcode, op};
        state_d = StFetch;  // unrecognised codes run as a NOP
        case (opcode)
          3'b110: begin
            if (op == 2'b10)      state_d = StWrImm;
            else if (op == 2'b00) state_d = StGetB;
          end
          // MVN has no Rn operand, so it skips GET_A.
          3'b101:  state_d = (op == 2'b11) ? StGetB : StGetA;
          3'b011:  if (op == 2'b00) state_d = StGetA;
          3'b100:  if (op == 2'b00) state_d = StGetA;
          3'b111:  state_d = StHalt;
          default: state_d = StFetch;
        endcase
      end
      StWrImm: state_d = StFetch;
      StGetA:  state_d = (ins_q[4:2] == OpcAlu) ? StGetB : StAddr;
      StGetB:  state_d = StExec;
      StExec:  state_d = (ins_q == InsCmp) ? StFetch : StWrRd;
      StWrRd:  state_d = StFetch;
      StAddr:  state_d = (ins_q[4:2] == OpcLdr) ? StMemRd : StGetD;
      StMemRd: state_d = StWrMem;
      StWrMem: state_d = StFetch;
      StGetD:  state_d = StSt;
      StSt:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  // Moore outputs.
  always_comb begin
    nsel     = 3'b000;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    write    = 1'b0;
    loadir   = 1'b0;
    loadpc   = 1'b0;
    reset_pc = 1'b0;
    msel     = 1'b0;
    mwrite   = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StReset: begin
        reset_pc = 1'b1;
        loadpc   = 1'b1;
      end
      StLoadIr:   loadir = 1'b1;
      StUpdatePc: loadpc = 1'b1;
      StWrImm: begin
        nsel  = 3'b001;
        vsel  = 2'b01;
        write = 1'b1;
      end
      StGetA: begin
        nsel  = 3'b001;
        loada = 1'b1;
      end
      StGetB: begin
        nsel  = 3'b100;
        loadb = 1'b1;
      end
      StExec: begin
        // CMP only updates the status flags; C is left untouched.
        loadc = (ins_q != InsCmp);
        loads = (ins_q == InsCmp);
        asel  = (ins_q == InsMovReg) || (ins_q == InsMvn);
      end
      StWrRd: begin
        nsel  = 3'b010;
        vsel  = 2'b00;
        write = 1'b1;
      end
      StAddr: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      StMemRd: msel = 1'b1;
      StWrMem: begin
        msel  = 1'b1;
        nsel  = 3'b010;
        vsel  = 2'b10;
        write = 1'b1;
      end
      StGetD: begin
        nsel  = 3'b010;
        loadb = 1'b1;
      end
      StSt: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: an instruction-level model expands each instruction into the list
// of control vectors it must produce; one compare process checks the DUT every cycle.
module tb_cpu_controller;

  localparam int unsigned Hold    = 1;
  localparam int          HaltLen = 20;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write, loadir, loadpc;
    logic       reset_pc, msel, mwrite, halted;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada, loadb, loadc, loads, asel, bsel, write, loadir, loadpc;
  logic       reset_pc, msel, mwrite, halted;

  always #5 clk = ~clk;

  cpu_controller #(
    .RESET_HOLD(Hold)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .op      (op),
    .nsel    (nsel),
    .vsel    (vsel),
    .loada   (loada),
    .loadb   (loadb),
    .loadc   (loadc),
    .loads   (loads),
    .asel    (asel),
    .bsel    (bsel),
    .write   (write),
    .loadir  (loadir),
    .loadpc  (loadpc),
    .reset_pc(reset_pc),
    .msel    (msel),
    .mwrite  (mwrite),
    .halted  (halted)
  );

  ctl_t  act;
  ctl_t  exp_v;
  logic  chk_en = 1'b0;
  int    total = 0;
  int    bad = 0;
  string tag = "none";
  ctl_t  seq[$];

  assign act = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, loadir, loadpc,
                reset_pc, msel, mwrite, halted};

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL %s got=%b want=%b", tag, act, exp_v);
      end
    end
  end

  // Vector constructors in instruction-level terms.
  function automatic ctl_t rd_reg(input logic [2:0] n, input logic into_a);
    ctl_t v = '0;
    v.nsel = n;
    if (into_a) v.loada = 1'b1;
    else        v.loadb = 1'b1;
    return v;
  endfunction

  function automatic ctl_t wr_back(input logic [2:0] n, input logic [1:0] src);
    ctl_t v = '0;
    v.nsel  = n;
    v.vsel  = src;
    v.write = 1'b1;
    v.msel  = (src == 2'b10);  // memory data needs the RAM still addressed by C
    return v;
  endfunction

  function automatic ctl_t alu_step(input logic zero_a, input logic flags_only);
    ctl_t v = '0;
    v.asel  = zero_a;
    v.loadc = !flags_only;
    v.loads = flags_only;
    return v;
  endfunction

  // Expand one instruction into the control vectors from FETCH to its last state.
  function automatic void build_seq(input logic [2:0] opc, input logic [1:0] o);
    ctl_t v;
    logic movi, movr, alu, mvn, cmp, ldr, str, hlt;
    movi = (opc == 3'd6) && (o == 2'd2);
    movr = (opc == 3'd6) && (o == 2'd0);
    alu  = (opc == 3'd5);
    mvn  = alu && (o == 2'd3);
    cmp  = alu && (o == 2'd1);
    ldr  = (opc == 3'd3) && (o == 2'd0);
    str  = (opc == 3'd4) && (o == 2'd0);
    hlt  = (opc == 3'd7);
    seq.delete();
    v = '0;              seq.push_back(v);  // fetch
    v = '0; v.loadir = 1; seq.push_back(v);
    v = '0; v.loadpc = 1; seq.push_back(v);
    v = '0;              seq.push_back(v);  // decode
    if (movi) begin
      seq.push_back(wr_back(3'b001, 2'b01));
    end else if (movr || mvn) begin
      seq.push_back(rd_reg(3'b100, 1'b0));
      seq.push_back(alu_step(1'b1, 1'b0));
      seq.push_back(wr_back(3'b010, 2'b00));
    end else if (alu) begin
      seq.push_back(rd_reg(3'b001, 1'b1));
      seq.push_back(rd_reg(3'b100, 1'b0));
      seq.push_back(alu_step(1'b0, cmp));
      if (!cmp) seq.push_back(wr_back(3'b010, 2'b00));
    end else if (ldr || str) begin
      seq.push_back(rd_reg(3'b001, 1'b1));
      v = '0; v.bsel = 1; v.loadc = 1; seq.push_back(v);
      if (ldr) begin
        v = '0; v.msel = 1; seq.push_back(v);
        seq.push_back(wr_back(3'b010, 2'b10));
      end else begin
        seq.push_back(rd_reg(3'b010, 1'b0));
        v = '0; v.msel = 1; v.mwrite = 1; seq.push_back(v);
      end
    end else if (hlt) begin
      for (int k = 0; k < HaltLen; k++) begin
        v = '0; v.halted = 1; seq.push_back(v);
      end
    end
  endfunction

  task automatic chk_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic do_reset(input int n_low);
    ctl_t v = '0;
    v.reset_pc = 1'b1;
    v.loadpc   = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < n_low; i++) begin
      @(posedge clk); #1;
      exp_v = v; tag = $sformatf("reset_low[%0d]", i); chk_en = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < int'(Hold); i++) begin
      @(posedge clk); #1;
      exp_v = v; tag = $sformatf("reset_hold[%0d]", i);
    end
  endtask

  // Fields are only valid during DECODE; every other cycle carries junk.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input string name,
                           input int abort_at);
    build_seq(opc, o);
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge clk); #1;
      if (i == 3) {opcode, op} = {opc, o};
      else        {opcode, op} = 5'($urandom);
      exp_v = seq[i];
      tag   = $sformatf("%s[%0d]", name, i);
      if (i == abort_at) break;
    end
  endtask

  initial begin
    // Pin the model against hand-derived cycle counts and vectors.
    build_seq(3'b110, 2'b10);
    chk_lit("len_movi", 32'(seq.size()), 32'd5);
    chk_lit("vec_wrimm", 32'(seq[4]), 32'(18'b001_01_000000100_0000));
    build_seq(3'b110, 2'b00);
    chk_lit("len_movr", 32'(seq.size()), 32'd7);
    build_seq(3'b101, 2'b00);
    chk_lit("len_add", 32'(seq.size()), 32'd8);
    build_seq(3'b101, 2'b01);
    chk_lit("len_cmp", 32'(seq.size()), 32'd7);
    chk_lit("vec_cmp_exec", 32'(seq[6]), 32'(18'b000_00_000100000_0000));
    build_seq(3'b011, 2'b00);
    chk_lit("len_ldr", 32'(seq.size()), 32'd8);
    build_seq(3'b100, 2'b00);
    chk_lit("len_str", 32'(seq.size()), 32'd8);
    chk_lit("vec_st", 32'(seq[7]), 32'(18'b000_00_000000000_0110));

    do_reset(3);
    run_instr(3'b110, 2'b10, "movi", -1);
    run_instr(3'b110, 2'b00, "movr", -1);
    run_instr(3'b101, 2'b00, "add", -1);
    run_instr(3'b101, 2'b10, "and", -1);
    run_instr(3'b101, 2'b11, "mvn", -1);
    run_instr(3'b101, 2'b01, "cmp", -1);
    run_instr(3'b011, 2'b00, "ldr", -1);
    run_instr(3'b100, 2'b00, "str", -1);
    run_instr(3'b000, 2'b00, "nop0", -1);
    run_instr(3'b011, 2'b01, "nop_ldr_op", -1);
    run_instr(3'b101, 2'b00, "add_abort", 6);  // reset lands during EXEC
    do_reset(1);
    run_instr(3'b000, 2'b00, "nop_after", -1);
    run_instr(3'b111, 2'b00, "halt", -1);
    do_reset(1);
    run_instr(3'b110, 2'b10, "movi_after_halt", -1);
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
